// File: rtl/ksa_pkg.sv
// -----------------------------------------------------------------------------
// ksa_pkg
// Shared types and constants for the RC4 key-scheduling engine.
//   ksa_state_t      - engine FSM state encoding
//   SWAP_ITER_CYCLES - clock cycles spent on one swap iteration (one value of i)
// -----------------------------------------------------------------------------
package ksa_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FILL,
    RD_I,
    WAIT_I,
    CAP_I,
    RD_J,
    WAIT_J,
    CAP_J,
    WR_I,
    WR_J,
    DONE
  } ksa_state_t;

  localparam int SWAP_ITER_CYCLES = 8;

endpackage : ksa_pkg

// File: rtl/ksa_key_sel.sv
// -----------------------------------------------------------------------------
// ksa_key_sel
// Key-byte sequencer for the key-scheduling loop. Holds the key byte index k,
// which advances by one on each 'advance' pulse and wraps back to 0 after
// KEY_BYTES-1, so no modulo hardware is needed. Outputs key byte k resized
// to ADDR_W bits (truncated when ADDR_W < 8, zero-extended when ADDR_W > 8).
//
// Ports:
//   clk      in  1             sole clock
//   reset    in  1             synchronous, active-high; k <= 0
//   clear    in  1             k <= 0 (start of a new run); wins over advance
//   advance  in  1             step k to the next key byte
//   key      in  8*KEY_BYTES   key, byte 0 in the most significant byte
//   key_byte out ADDR_W        key byte k, resized to ADDR_W
// -----------------------------------------------------------------------------
module ksa_key_sel #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   advance,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [ADDR_W-1:0]      key_byte
);

  localparam int K_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  logic [K_W-1:0] k_q;
  logic [K_W-1:0] k_d;
  logic [7:0]     sel;

  // Wrap counter: back to 0 after the last key byte.
  assign k_d = (k_q == K_W'(KEY_BYTES - 1)) ? '0 : k_q + K_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      k_q <= '0;
    end else if (advance) begin
      k_q <= k_d;
    end
  end

  // NOTE: 'sel' gets a default before the loop; without it some k values
  // would leave it unassigned and the tool would infer a latch.
  always_comb begin
    sel = 8'h00;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k_q == K_W'(b)) begin
        sel = key[8*(KEY_BYTES-b)-1 -: 8];
      end
    end
  end

  generate
    if (ADDR_W < 8) begin : g_trunc
      logic unused_sel_hi;
      assign unused_sel_hi = ^sel[7:ADDR_W];
      assign key_byte      = sel[ADDR_W-1:0];
    end else if (ADDR_W > 8) begin : g_zext
      assign key_byte = {{(ADDR_W-8){1'b0}}, sel};
    end else begin : g_same
      assign key_byte = sel;
    end
  endgenerate

endmodule : ksa_key_sel

// File: rtl/ksa_engine.sv
// -----------------------------------------------------------------------------
// ksa_engine
// RC4 key-scheduling engine driving a single-port RAM (registered inputs,
// unregistered q). A run first writes the identity permutation RAM[x] = x,
// one write per clock, then (when KSA_SWAP_EN is defined) performs the RC4
// key-scheduling swap loop at 8 cycles per i. With KSA_SWAP_EN undefined the
// engine only fills, and the swap datapath and key logic are not built.
//
// Configuration macro: KSA_SWAP_EN
//
// Ports:
//   clk       in  1            sole clock
//   reset     in  1            synchronous, active-high; aborts any run
//   start     in  1            run request, accepted in IDLE or DONE
//   key       in  8*KEY_BYTES  key, byte 0 = key[8*KEY_BYTES-1 -: 8]
//   busy      out 1            high from the cycle after an accepted start
//   done      out 1            level, high after completion until next start
//   mem_addr  out ADDR_W       RAM address (registered)
//   mem_wdata out ADDR_W       RAM write data (registered)
//   mem_wren  out 1            RAM write enable (registered)
//   mem_rdata in  ADDR_W       RAM q
//   dbg_index out ADDR_W       current i
// -----------------------------------------------------------------------------
module ksa_engine
  import ksa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [ADDR_W-1:0]      mem_wdata,
  output logic                   mem_wren,
  input  logic [ADDR_W-1:0]      mem_rdata,
  output logic [ADDR_W-1:0]      dbg_index
);

  ksa_state_t        state_q;
  logic [ADDR_W-1:0] i_q;
  logic [ADDR_W-1:0] i_d;
  logic              i_last;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wdata_q;
  logic              wren_q;
  logic              start_accept;

  assign i_d          = i_q + ADDR_W'(1);
  assign i_last       = (i_q == '1);
  assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef KSA_SWAP_EN
  logic [ADDR_W-1:0] j_q;
  logic [ADDR_W-1:0] j_d;
  logic [ADDR_W-1:0] si_q;
  logic [ADDR_W-1:0] sj_q;
  logic [ADDR_W-1:0] key_byte;

  ksa_key_sel #(
    .ADDR_W    (ADDR_W),
    .KEY_BYTES (KEY_BYTES)
  ) u_key_sel (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_accept),
    .advance  (state_q == WR_J),
    .key      (key),
    .key_byte (key_byte)
  );

  // In CAP_I mem_rdata holds S[i]; the modulo-2^ADDR_W wrap is the natural
  // overflow of the ADDR_W-bit adder.
  assign j_d = j_q + mem_rdata + key_byte;
`else
  logic unused_inputs;
  assign unused_inputs = ^{key, mem_rdata};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
`ifdef KSA_SWAP_EN
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_accept) begin
            state_q <= FILL;
            i_q     <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef KSA_SWAP_EN
            j_q     <= '0;
`endif
          end
        end

        FILL: begin
          addr_q  <= i_q;
          wdata_q <= i_q;
          wren_q  <= 1'b1;
          i_q     <= i_d;
          if (i_last) begin
`ifdef KSA_SWAP_EN
            state_q <= RD_I;
`else
            state_q <= DONE;
`endif
          end
        end

`ifdef KSA_SWAP_EN
        // RAM samples the address one edge after it is loaded here and its
        // q is stable to capture one edge after that, hence the WAIT states.
        RD_I: begin
          addr_q  <= i_q;
          wren_q  <= 1'b0;
          state_q <= WAIT_I;
        end

        WAIT_I: state_q <= CAP_I;

        CAP_I: begin
          si_q    <= mem_rdata;
          j_q     <= j_d;
          state_q <= RD_J;
        end

        RD_J: begin
          addr_q  <= j_q;
          state_q <= WAIT_J;
        end

        WAIT_J: state_q <= CAP_J;

        CAP_J: begin
          sj_q    <= mem_rdata;
          state_q <= WR_I;
        end

        // When i == j both writes hit one address with the same value,
        // leaving the RAM unchanged, so no special case is needed.
        WR_I: begin
          addr_q  <= i_q;
          wdata_q <= sj_q;
          wren_q  <= 1'b1;
          state_q <= WR_J;
        end

        WR_J: begin
          addr_q  <= j_q;
          wdata_q <= si_q;
          wren_q  <= 1'b1;
          i_q     <= i_d;
          state_q <= i_last ? DONE : RD_I;
        end
`endif

        DONE: begin
          // The last write was loaded on the edge that entered DONE; it has
          // reached the RAM by now, so write enable can drop.
          wren_q <= 1'b0;
          busy_q <= 1'b0;
          if (start_accept) begin
            state_q <= FILL;
            i_q     <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef KSA_SWAP_EN
            j_q     <= '0;
`endif
          end else begin
            done_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wren  = wren_q;
  assign dbg_index = i_q;

endmodule : ksa_engine

// File: tb/tb_ksa_engine.sv
// -----------------------------------------------------------------------------
// tb_ksa_engine
// Directed bench for ksa_engine. Two engines share clk/reset: an 8-bit
// engine with a 3-byte key and a 2-bit engine with a 1-byte key, each wired
// to its own single-port RAM model (registered inputs, read-old-data q).
// The swap-specific checks are compiled when KSA_SWAP_EN is defined.
// -----------------------------------------------------------------------------
module tb_ksa_engine;
  import ksa_pkg::*;

`ifdef KSA_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  localparam int N8 = 256 + 1 + (SWAP ? SWAP_ITER_CYCLES * 256 : 0);
  localparam int N2 = 4 + 1 + (SWAP ? SWAP_ITER_CYCLES * 4 : 0);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start8;
  logic [23:0] key8;
  logic        busy8, done8, wren8;
  logic [7:0]  addr8, wdata8, rdata8, dbg8;

  logic        start2;
  logic [7:0]  key2;
  logic        busy2, done2, wren2;
  logic [1:0]  addr2, wdata2, rdata2, dbg2;

  logic [7:0]  mem8 [256];
  logic [1:0]  mem2 [4];
  logic        scr8;

  int n_checks = 0;
  int n_pass   = 0;

  ksa_engine #(.ADDR_W(8), .KEY_BYTES(3)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .start     (start8),
    .key       (key8),
    .busy      (busy8),
    .done      (done8),
    .mem_addr  (addr8),
    .mem_wdata (wdata8),
    .mem_wren  (wren8),
    .mem_rdata (rdata8),
    .dbg_index (dbg8)
  );

  ksa_engine #(.ADDR_W(2), .KEY_BYTES(1)) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .start     (start2),
    .key       (key2),
    .busy      (busy2),
    .done      (done2),
    .mem_addr  (addr2),
    .mem_wdata (wdata2),
    .mem_wren  (wren2),
    .mem_rdata (rdata2),
    .dbg_index (dbg2)
  );

  // RAM models; scr8 fills mem8 with a non-identity pattern so a rerun has
  // to rewrite every location to pass.
  always @(posedge clk) begin
    if (scr8) begin
      for (int x = 0; x < 256; x++) mem8[x] <= 8'(x ^ 8'h5A);
    end else if (wren8) begin
      mem8[addr8] <= wdata8;
    end
    rdata8 <= mem8[addr8];
  end

  always @(posedge clk) begin
    if (wren2) mem2[addr2] <= wdata2;
    rdata2 <= mem2[addr2];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pulse_start(input bit use2);
    @(negedge clk);
    if (use2) start2 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    start8 = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen. With poke set,
  // start is pulsed repeatedly early in the run and must be ignored.
  task automatic wait_done(input bit use2, input int limit, input bit poke, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (use2) start2 = poke && (cycles < 100) && (cycles % 5 == 2);
      else      start8 = poke && (cycles < 100) && (cycles % 5 == 2);
    end while (!(use2 ? done2 : done8) && cycles < limit);
    start2 = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic scramble8();
    @(negedge clk);
    scr8 = 1'b1;
    @(negedge clk);
    scr8 = 1'b0;
  endtask

  function automatic int fill_errors8();
    int e = 0;
    for (int x = 0; x < 256; x++) if (mem8[x] !== 8'(x)) e++;
    return e;
  endfunction

  // Software RC4 KSA (MSB-first key bytes) compared against mem8.
  function automatic int ksa8_errors(input logic [23:0] k);
    logic [7:0] s [256];
    logic [7:0] j;
    logic [7:0] t;
    int e = 0;
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    j = 8'h00;
    for (int x = 0; x < 256; x++) begin
      j    = j + s[x] + k[23 - 8*(x % 3) -: 8];
      t    = s[x];
      s[x] = s[j];
      s[j] = t;
    end
    for (int x = 0; x < 256; x++) if (mem8[x] !== s[x]) e++;
    return e;
  endfunction

  function automatic int ram8_errors(input logic [23:0] k);
    return SWAP ? ksa8_errors(k) : fill_errors8();
  endfunction

  function automatic logic [7:0] mem2_packed();
    return {mem2[3], mem2[2], mem2[1], mem2[0]};
  endfunction

  initial begin
    int cyc;
    int bad;
    bit found;

    reset  = 1'b1;
    start8 = 1'b0;
    start2 = 1'b0;
    scr8   = 1'b0;
    key8   = 24'h000249;
    key2   = 8'h00;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  32'(busy8),  32'd0);
    check("rst_done",  32'(done8),  32'd0);
    check("rst_addr",  32'(addr8),  32'd0);
    check("rst_wdata", 32'(wdata8), 32'd0);
    check("rst_wren",  32'(wren8),  32'd0);
    check("rst_dbg",   32'(dbg8),   32'd0);
    check("rst_busy2", 32'(busy2),  32'd0);
    check("rst_done2", 32'(done2),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Full run on the 8-bit engine with start poked while busy.
    pulse_start(1'b0);
    check("busy_after_start", 32'(busy8), 32'd1);
    wait_done(1'b0, N8 + 50, 1'b1, cyc);
    check("done8_latency", 32'(cyc), 32'(N8));
    check("busy8_at_done", 32'(busy8), 32'd0);
    check("ram8_run1", 32'(ram8_errors(key8)), 32'd0);
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (wren8 || !done8) bad++;
    end
    check("quiet_after_done8", 32'(bad), 32'd0);

    // Restart from DONE over a scrambled RAM.
    scramble8();
    pulse_start(1'b0);
    check("restart_done_drops", 32'(done8), 32'd0);
    check("restart_busy",       32'(busy8), 32'd1);
    wait_done(1'b0, N8 + 50, 1'b0, cyc);
    check("done8_latency_rerun", 32'(cyc), 32'(N8));
    check("ram8_rerun", 32'(ram8_errors(key8)), 32'd0);

    // 2-bit engine, key 0x00: identity when fill-only, {0,2,3,1} with swap.
    pulse_start(1'b1);
    wait_done(1'b1, N2 + 50, 1'b0, cyc);
    check("done2_latency", 32'(cyc), 32'(N2));
    check("ram2_key00", 32'(mem2_packed()), SWAP ? 32'h78 : 32'hE4);

`ifdef KSA_SWAP_EN
    // 2-bit engine, key 0x01: {1,0,2,3} after i=0, final {0,2,3,1}.
    key2 = 8'h01;
    pulse_start(1'b1);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk);
      #1;
      if (dbg2 == 2'd1 && busy2) found = 1'b1;
    end
    check("ram2_reach_i1", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    check("ram2_key01_i0", 32'(mem2_packed()), 32'hE1);
    wait_done(1'b1, N2 + 50, 1'b0, cyc);
    check("ram2_key01_final", 32'(mem2_packed()), 32'h78);
`endif

    // Reset while running at i = 0x40 (inside the swap loop when enabled).
    pulse_start(1'b0);
    found = 1'b0;
    for (int c = 1; c < N8 + 50 && !found; c++) begin
      @(posedge clk);
      #1;
      if (c > (SWAP ? 256 : 0) && dbg8 == 8'h40) found = 1'b1;
    end
    check("reach_i40", 32'(found), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_wren", 32'(wren8), 32'd0);
    check("midrst_addr", 32'(addr8), 32'd0);
    check("midrst_dbg",  32'(dbg8),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    scramble8();
    pulse_start(1'b0);
    wait_done(1'b0, N8 + 50, 1'b0, cyc);
    check("done8_latency_after_rst", 32'(cyc), 32'(N8));
    check("ram8_after_rst", 32'(ram8_errors(key8)), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ksa_engine
